// File: rtl/sw_fpga_pkg.sv
// sw_fpga_pkg: shared types and constants for the SW-core display path.
//   fmt_state_t  : state encoding of the binary-to-BCD formatter FSM
//   FMT_DATA_W   : default binary input width (26-bit timers, zero-extended score)
//   FMT_DIGITS   : default number of BCD digits driven to HEX0..HEX7
//   bcd_adj3()   : shift-add-3 correction for one BCD digit
package sw_fpga_pkg;

  typedef enum logic [1:0] {
    FMT_IDLE,
    FMT_SHIFT,
    FMT_DONE
  } fmt_state_t;

  localparam int unsigned FMT_DATA_W = 26;
  localparam int unsigned FMT_DIGITS = 8;

  // Digits entering a shift are always 0..9, so d+3 never exceeds 12 and
  // the correction stays inside the digit.
  function automatic logic [3:0] bcd_adj3(input logic [3:0] d);
    return (d >= 4'd5) ? (d + 4'd3) : d;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: combinational add-3 correction applied to one BCD digit
// before each shift of the double-dabble accumulator.
//   digit_in  : current accumulator digit
//   digit_out : digit after the conditional +3
module bcd_digit_adj
  import sw_fpga_pkg::*;
(
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  always_comb begin
    digit_out = bcd_adj3(digit_in);
  end

endmodule

// File: rtl/score_bcd_formatter.sv
// score_bcd_formatter: sequential binary-to-BCD converter (shift-add-3)
// sitting between the SW-core score/timer values and the seven-segment bank.
//   clk, rst_n : system clock, asynchronous active-low reset
//   i_valid    : request strobe, i_data sampled in the same cycle
//   i_data     : unsigned value to convert
//   i_clear    : synchronous clear of outputs, FSM and pending buffer
//   o_busy     : high while shifting
//   o_valid    : one-cycle pulse when o_bcd/o_blank/o_ovf update
//   o_bcd      : packed BCD, digit0 in [3:0], held until next o_valid
//   o_blank    : bit k set when digit k is a leading zero (bit 0 never set)
//   o_ovf      : value did not fit in DIGITS digits; o_bcd has the low digits
// Requests arriving while a conversion runs land in a one-deep pending
// buffer (last value wins) and are started straight from the DONE cycle.
module score_bcd_formatter
  import sw_fpga_pkg::*;
#(
  parameter int unsigned DATA_W = FMT_DATA_W,
  parameter int unsigned DIGITS = FMT_DIGITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_valid,
  input  logic [DATA_W-1:0]     i_data,
  input  logic                  i_clear,
  output logic                  o_busy,
  output logic                  o_valid,
  output logic [4*DIGITS-1:0]   o_bcd,
  output logic [DIGITS-1:0]     o_blank,
  output logic                  o_ovf
);

  localparam int unsigned ACC_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(DATA_W + 1);
  localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

  fmt_state_t          state;
  fmt_state_t          state_nxt;

  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    acc_adj;
  logic [DATA_W-1:0]   shreg;
  logic [CNT_W-1:0]    cnt;
  logic                ovf_sticky;
  logic                pend_full;
  logic [DATA_W-1:0]   pend_data;
  logic [DIGITS-1:0]   blank_nxt;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_in  (acc[4*g +: 4]),
      .digit_out (acc_adj[4*g +: 4])
    );
  end

  // A digit is blank when it and every digit above it are zero; digit 0 is
  // always shown so a zero value displays a single "0".
  always_comb begin
    logic zero_run;
    zero_run  = 1'b1;
    blank_nxt = '0;
    for (int unsigned k = DIGITS; k > 1; k--) begin
      zero_run       = zero_run & (acc[4*(k-1) +: 4] == 4'd0);
      blank_nxt[k-1] = zero_run;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FMT_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // DATA_W shifts: the counter is loaded with DATA_W and the last shift is
  // the one taken while it reads 1.
  always_comb begin
    state_nxt = state;
    case (state)
      FMT_IDLE:  if (i_valid) state_nxt = FMT_SHIFT;
      FMT_SHIFT: if (cnt == CNT_W'(1)) state_nxt = FMT_DONE;
      FMT_DONE:  state_nxt = (i_valid || pend_full) ? FMT_SHIFT : FMT_IDLE;
      default:   state_nxt = FMT_IDLE;
    endcase
    if (i_clear) begin
      state_nxt = FMT_IDLE;
    end
  end

  always_comb begin
    o_busy = (state == FMT_SHIFT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      shreg      <= '0;
      cnt        <= '0;
      ovf_sticky <= 1'b0;
      pend_full  <= 1'b0;
      pend_data  <= '0;
      o_valid    <= 1'b0;
      o_bcd      <= '0;
      o_blank    <= BLANK_RST;
      o_ovf      <= 1'b0;
    end else if (i_clear) begin
      acc        <= '0;
      shreg      <= '0;
      cnt        <= '0;
      ovf_sticky <= 1'b0;
      pend_full  <= 1'b0;
      pend_data  <= '0;
      o_valid    <= 1'b0;
      o_bcd      <= '0;
      o_blank    <= BLANK_RST;
      o_ovf      <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      case (state)
        FMT_IDLE: begin
          if (i_valid) begin
            shreg      <= i_data;
            acc        <= '0;
            cnt        <= CNT_W'(DATA_W);
            ovf_sticky <= 1'b0;
          end
        end
        FMT_SHIFT: begin
          {acc, shreg} <= {acc_adj[ACC_W-2:0], shreg, 1'b0};
          ovf_sticky   <= ovf_sticky | acc_adj[ACC_W-1];
          cnt          <= cnt - CNT_W'(1);
          if (i_valid) begin
            pend_data <= i_data;
            pend_full <= 1'b1;
          end
        end
        FMT_DONE: begin
          o_bcd   <= acc;
          o_blank <= blank_nxt;
          o_ovf   <= ovf_sticky;
          o_valid <= 1'b1;
          // A fresh request in this cycle wins over the buffered one.
          if (i_valid || pend_full) begin
            shreg      <= i_valid ? i_data : pend_data;
            acc        <= '0;
            cnt        <= CNT_W'(DATA_W);
            ovf_sticky <= 1'b0;
          end
          pend_full <= 1'b0;
        end
        default: begin
          pend_full <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_score_bcd_formatter.sv
// tb_score_bcd_formatter: randomized self-checking bench for the BCD formatter.
// Default build (26-bit / 8 digits) plus a 16-bit / 4-digit build.
module tb_score_bcd_formatter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // default build
  logic        a_valid = 1'b0;
  logic [25:0] a_data = '0;
  logic        a_clear = 1'b0;
  logic        a_busy, a_o_valid, a_o_ovf;
  logic [31:0] a_o_bcd;
  logic [7:0]  a_o_blank;

  // narrow build
  logic        b_valid = 1'b0;
  logic [15:0] b_data = '0;
  logic        b_clear = 1'b0;
  logic        b_busy, b_o_valid, b_o_ovf;
  logic [15:0] b_o_bcd;
  logic [3:0]  b_o_blank;

  score_bcd_formatter #(.DATA_W(26), .DIGITS(8)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .i_valid(a_valid), .i_data(a_data), .i_clear(a_clear),
    .o_busy(a_busy), .o_valid(a_o_valid), .o_bcd(a_o_bcd), .o_blank(a_o_blank), .o_ovf(a_o_ovf)
  );

  score_bcd_formatter #(.DATA_W(16), .DIGITS(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .i_valid(b_valid), .i_data(b_data), .i_clear(b_clear),
    .o_busy(b_busy), .o_valid(b_o_valid), .o_bcd(b_o_bcd), .o_blank(b_o_blank), .o_ovf(b_o_ovf)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference arithmetic ----------------
  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned p = 1;
    for (int unsigned i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [31:0] ref_bcd(input longint unsigned v, input int unsigned nd);
    logic [31:0] r = '0;
    longint unsigned x = v;
    for (int unsigned k = 0; k < nd; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [7:0] ref_blank(input longint unsigned v, input int unsigned nd);
    logic [7:0] b = '0;
    longint unsigned m = v % pow10(nd);
    for (int unsigned k = 1; k < nd; k++) b[k] = (m < pow10(k));
    return b;
  endfunction

  function automatic logic ref_ovf(input longint unsigned v, input int unsigned nd);
    return v >= pow10(nd);
  endfunction

  // ---------------- result capture (default build) ----------------
  typedef struct {
    int unsigned cyc;
    logic [31:0] bcd;
    logic [7:0]  blank;
    logic        ovf;
  } ev_t;
  ev_t ev_q[$];

  always @(negedge clk) begin
    if (a_o_valid) ev_q.push_back('{cyc, a_o_bcd, a_o_blank, a_o_ovf});
  end

  // ---------------- transaction timeline model ----------------
  // A conversion started at cycle s reports at s+27. Requests during a
  // conversion are remembered (latest wins) and start at the report cycle;
  // a request arriving exactly at the report cycle replaces the remembered one.
  typedef struct {
    int unsigned cyc;
    logic [25:0] v;
  } exp_t;
  exp_t        exp_q[$];
  bit          m_active;
  int unsigned m_end;
  bit          m_pend_v;
  logic [25:0] m_pend;

  task automatic model_reset();
    m_active = 0;
    m_pend_v = 0;
    m_end    = 0;
    exp_q.delete();
    ev_q.delete();
  endtask

  task automatic m_start(input int unsigned t, input logic [25:0] v);
    m_active = 1;
    m_end    = t + 27;
    exp_q.push_back('{m_end, v});
  endtask

  // Drive one cycle of the default build (called just after a rising edge).
  task automatic step(input bit req, input logic [25:0] v);
    int unsigned t;
    a_valid = req;
    a_data  = v;
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    t = cyc;
    if (m_active && t == m_end) begin
      if (req) m_start(t, v);
      else if (m_pend_v) m_start(t, m_pend);
      else m_active = 0;
      m_pend_v = 0;
    end else if (m_active) begin
      if (req) begin
        m_pend   = v;
        m_pend_v = 1;
      end
    end else if (req) begin
      m_start(t, v);
    end
  endtask

  task automatic compare_events(input string tag);
    int unsigned n;
    check({tag, "_count"}, ev_q.size(), exp_q.size());
    n = (ev_q.size() < exp_q.size()) ? ev_q.size() : exp_q.size();
    for (int unsigned i = 0; i < n; i++) begin
      check({tag, "_cyc"},   ev_q[i].cyc,   exp_q[i].cyc);
      check({tag, "_bcd"},   ev_q[i].bcd,   ref_bcd(exp_q[i].v, 8));
      check({tag, "_blank"}, ev_q[i].blank, ref_blank(exp_q[i].v, 8));
      check({tag, "_ovf"},   ev_q[i].ovf,   ref_ovf(exp_q[i].v, 8));
    end
  endtask

  task automatic do_a(input logic [25:0] v, input logic [31:0] eb, input logic [7:0] ebl,
                      input logic eo);
    int unsigned t0;
    model_reset();
    step(1, v);
    t0 = cyc;
    repeat (35) step(0, '0);
    check("a_count", ev_q.size(), 1);
    if (ev_q.size() >= 1) begin
      check("a_latency", ev_q[0].cyc - t0, 27);
      check("a_bcd",     ev_q[0].bcd, eb);
      check("a_blank",   ev_q[0].blank, ebl);
      check("a_ovf",     ev_q[0].ovf, eo);
    end
  endtask

  task automatic check_a_reset(input string tag);
    check({tag, "_busy"},  a_busy, 1'b0);
    check({tag, "_valid"}, a_o_valid, 1'b0);
    check({tag, "_bcd"},   a_o_bcd, 32'h0);
    check({tag, "_blank"}, a_o_blank, 8'hFE);
    check({tag, "_ovf"},   a_o_ovf, 1'b0);
  endtask

  task automatic run_b(input logic [15:0] v);
    int unsigned t0;
    int unsigned lat;
    bit seen;
    b_valid = 1'b1;
    b_data  = v;
    @(posedge clk);
    #1;
    b_valid = 1'b0;
    t0   = cyc;
    seen = 0;
    for (int unsigned i = 0; i < 40 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (b_o_valid) seen = 1;
    end
    lat = cyc - t0;
    check("b_seen", seen, 1'b1);
    if (seen) begin
      check("b_latency", lat, 17);
      check("b_bcd",     b_o_bcd, ref_bcd(v, 4));
      check("b_blank",   b_o_blank, ref_blank(v, 4));
      check("b_ovf",     b_o_ovf, ref_ovf(v, 4));
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned t0;
    logic [25:0] v;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check_a_reset("rst");
    check("rst_b_blank", b_o_blank, 4'hE);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // directed vectors
    do_a(26'd0,        32'h00000000, 8'hFE, 1'b0);
    do_a(26'd12345,    32'h00012345, 8'hE0, 1'b0);
    do_a(26'd67108863, 32'h67108863, 8'h00, 1'b0);
    do_a(26'd9,        32'h00000009, 8'hFE, 1'b0);
    do_a(26'd10,       32'h00000010, 8'hFC, 1'b0);

    // random single conversions
    for (int i = 0; i < 12; i++) begin
      v = 26'($urandom) & 26'((32'd1 << $urandom_range(1, 26)) - 1);
      do_a(v, ref_bcd(v, 8), ref_blank(v, 8), ref_ovf(v, 8));
    end

    // pending buffer: last request wins
    model_reset();
    step(1, 26'd7);
    t0 = cyc;
    repeat (4) step(0, '0);
    step(1, 26'd100);
    repeat (3) step(0, '0);
    step(1, 26'd200);
    repeat (75) step(0, '0);
    check("pend_count", ev_q.size(), 2);
    if (ev_q.size() >= 2) begin
      check("pend_first_lat",  ev_q[0].cyc - t0, 27);
      check("pend_first_bcd",  ev_q[0].bcd, 32'h7);
      check("pend_second_lat", ev_q[1].cyc - t0, 54);
      check("pend_second_bcd", ev_q[1].bcd, 32'h200);
    end
    compare_events("pend_model");

    // request in DONE with a full pending buffer
    model_reset();
    step(1, 26'd5);
    t0 = cyc;
    repeat (9) step(0, '0);
    step(1, 26'd3);
    repeat (16) step(0, '0);
    step(1, 26'd4);
    repeat (70) step(0, '0);
    check("done_count", ev_q.size(), 2);
    if (ev_q.size() >= 2) begin
      check("done_first_bcd",  ev_q[0].bcd, 32'h5);
      check("done_second_lat", ev_q[1].cyc - t0, 54);
      check("done_second_bcd", ev_q[1].bcd, 32'h4);
    end
    compare_events("done_model");

    // reset in the middle of a conversion
    model_reset();
    step(1, 26'd999);
    repeat (10) step(0, '0);
    rst_n = 1'b0;
    #1;
    check_a_reset("midrst");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("midrst_no_valid", ev_q.size(), 0);
    do_a(26'd42, 32'h00000042, 8'hFC, 1'b0);

    // synchronous clear beats a same-cycle request and empties the buffer
    model_reset();
    step(1, 26'd123456);
    repeat (4) step(0, '0);
    step(1, 26'd555);
    repeat (4) step(0, '0);
    a_clear = 1'b1;
    step(1, 26'd77);
    a_clear = 1'b0;
    check_a_reset("clr");
    repeat (60) @(posedge clk);
    #1;
    check("clr_no_valid", ev_q.size(), 0);

    // random request timeline
    model_reset();
    for (int i = 0; i < 600; i++) begin
      v = 26'($urandom) & 26'((32'd1 << $urandom_range(1, 26)) - 1);
      step($urandom_range(0, 9) == 0, v);
    end
    repeat (70) step(0, '0);
    compare_events("rand");

    // narrow build: overflow boundary
    run_b(16'd65535);
    check("b_ovf_bcd_const", b_o_bcd, 16'h5535);
    check("b_ovf_flag_const", b_o_ovf, 1'b1);
    run_b(16'd9999);
    check("b_9999_const", b_o_bcd, 16'h9999);
    run_b(16'd10000);
    run_b(16'd0);
    for (int i = 0; i < 6; i++) run_b(16'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
